// File: rtl/pipe_ctrl.sv
// pipe_ctrl: chain of STAGES valid/data registers with ready/valid on both
// ends. It collapses bubbles, holds data under backpressure and flushes
// all stages on one edge. It also flags upstream protocol violations.
// Ports: clk, rst (async, active-low); in_valid/in_ready/in_data upstream;
//   out_valid/out_ready/out_data downstream; flush kills all stages;
//   occupancy = valid stage count; stall_cnt = backpressure cycles;
//   err = sticky protocol-violation flag.
// Optional: define PIPE_CTRL_PERF_EN to build the stall_cnt counter,
//   otherwise stall_cnt is tied to zero.
module pipe_ctrl #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             out_data,
   input  logic                         flush,
   output logic [$clog2(STAGES+1)-1:0]  occupancy,
   output logic [15:0]                  stall_cnt,
   output logic                         err
);

   localparam int OW = $clog2(STAGES+1);
   localparam logic [OW-1:0] ONE = OW'(1);

   logic [STAGES-1:0] v_q, v_d, adv;
   logic [WIDTH-1:0]  d_q [STAGES];
   logic [WIDTH-1:0]  d_d [STAGES];
   logic [OW-1:0]     occ_q, occ_d;
   logic              pend_q, pend_d;
   logic [WIDTH-1:0]  pdat_q;
   logic              err_q, err_d;
   logic              in_fire;

   // Stage i may load when the sink takes a word or any stage at or
   // downstream of i is empty; flattened form of the ready chain.
   always_comb begin
      adv = '0;
      for (int i = 0; i < STAGES; i++) begin
         adv[i] = out_ready;
         for (int j = i; j < STAGES; j++) begin
            if (!v_q[j]) adv[i] = 1'b1;
         end
      end
   end

   assign in_ready = rst & adv[0] & ~flush;
   assign in_fire  = in_valid & in_ready;

   always_comb begin
      v_d = v_q;
      d_d = d_q;
      if (flush) begin
         // Kill valids only; data registers keep their contents.
         v_d = '0;
      end else begin
         if (adv[0]) begin
            v_d[0] = in_fire;
            d_d[0] = in_data;
         end
         for (int i = 1; i < STAGES; i++) begin
            if (adv[i]) begin
               v_d[i] = v_q[i-1];
               d_d[i] = d_q[i-1];
            end
         end
      end
   end

   always_comb begin
      occ_d = '0;
      for (int i = 0; i < STAGES; i++) begin
         if (v_d[i]) occ_d = occ_d + ONE;
      end
   end

   // A payload offered but refused must reappear unchanged next cycle.
   assign pend_d = in_valid & ~in_ready & ~flush;
   assign err_d  = err_q |
                   (pend_q & (~in_valid | (in_data != pdat_q)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q    <= '0;
         for (int i = 0; i < STAGES; i++) d_q[i] <= '0;
         occ_q  <= '0;
         pend_q <= 1'b0;
         pdat_q <= '0;
         err_q  <= 1'b0;
      end else begin
         v_q    <= v_d;
         d_q    <= d_d;
         occ_q  <= occ_d;
         pend_q <= pend_d;
         pdat_q <= in_data;
         err_q  <= err_d;
      end
   end

   assign out_valid = v_q[STAGES-1];
   assign out_data  = d_q[STAGES-1];
   assign occupancy = occ_q;
   assign err       = err_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q <= '0;
      end else if (v_q[STAGES-1] && !out_ready &&
                   stall_q != 16'hFFFF) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 16'h0000;
`endif

endmodule
